// File: rtl/lcd_fill_ctrl.sv
// lcd_fill_ctrl
// Command/pixel sequencer in front of a byte-level SPI serializer.
// After reset it wakes the panel (SLPOUT, wake delay, COLMOD=RGB565, DISPON),
// then serves rectangle fills: CASET, RASET, RAMWR and N RGB565 pixels.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   fill_req              level request, sampled only in IDLE
//   fill_x0/x1, y0/y1     inclusive rectangle bounds
//   fill_color            RGB565 pixel, high byte sent first
//   fill_ack              1-cycle pulse: request accepted, operands latched
//   fill_err              1-cycle pulse with fill_ack: rectangle rejected
//   busy                  high in every state except IDLE
//   init_done             set when power-up completes, cleared by reset only
//   spi_data, spi_dc      byte to the serializer, 0 = command, 1 = data
//   spi_cs                panel chip select, active-low
//   spi_done              serializer finished shifting the presented byte
//   state_dbg             current FSM state encoding
//
// Byte handshake: a byte is "offered" whenever spi_cs is low; spi_data and
// spi_dc stay stable until the serializer pulses spi_done, and the next byte
// is presented on the very next clock edge. spi_done is ignored while spi_cs
// is high or in IDLE.
//
// All SPI-side outputs are registered from the next state, so they change
// on the same edge as the state and return to reset values during reset.

module lcd_fill_ctrl #(
    parameter int WAKE_CYCLES = 12_000_000,
    parameter int X_MAX       = 127,
    parameter int Y_MAX       = 159
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fill_req,
    input  logic [7:0]  fill_x0,
    input  logic [7:0]  fill_x1,
    input  logic [7:0]  fill_y0,
    input  logic [7:0]  fill_y1,
    input  logic [15:0] fill_color,
    output logic        fill_ack,
    output logic        fill_err,
    output logic        busy,
    output logic        init_done,
    output logic [7:0]  spi_data,
    output logic        spi_dc,
    output logic        spi_cs,
    input  logic        spi_done,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_INIT_SLPOUT = 4'd0,
        S_INIT_WAIT   = 4'd1,
        S_INIT_COLMOD = 4'd2,
        S_INIT_COLARG = 4'd3,
        S_INIT_DISPON = 4'd4,
        S_CS_GAP      = 4'd5,
        S_IDLE        = 4'd6,
        S_ACCEPT      = 4'd7,
        S_CASET_CMD   = 4'd8,
        S_CASET_ARG   = 4'd9,
        S_RASET_CMD   = 4'd10,
        S_RASET_ARG   = 4'd11,
        S_RAMWR       = 4'd12,
        S_PIX_HI      = 4'd13,
        S_PIX_LO      = 4'd14
    } state_t;

    // A zero wake time still spends one cycle with chip select high.
    localparam int unsigned WAKE_EFF  = (WAKE_CYCLES < 1) ? 1 : WAKE_CYCLES;
    localparam int unsigned WAKE_LAST = WAKE_EFF - 1;
    localparam int unsigned X_LIM     = X_MAX;
    localparam int unsigned Y_LIM     = Y_MAX;

    state_t      state, state_d;
    logic [31:0] wait_cnt, wait_d;
    logic [2:0]  arg_idx, arg_d;
    logic [15:0] pix_cnt, pix_d;

    logic [7:0]  x0_r, x1_r, y0_r, y1_r;
    logic [15:0] color_r;

    logic [7:0]  data_d;
    logic        dc_d;
    logic        cs_d;

    logic        byte_done;
    logic        accept;
    logic        rect_ok;
    logic [8:0]  dx, dy;
    logic [15:0] area;

    assign state_dbg = state;

    // Only a byte that is actually on the wire can complete.
    assign byte_done = spi_done && !spi_cs && (state != S_IDLE);
    assign accept    = (state == S_IDLE) && fill_req;

    assign rect_ok = (fill_x0 <= fill_x1) && (fill_y0 <= fill_y1) &&
                     ({24'd0, fill_x1} <= X_LIM) && ({24'd0, fill_y1} <= Y_LIM);

    // Pixel count from the raw inputs so it can be loaded on the accept edge.
    // Legal rectangles are at most 256x256 wide... but bounded by X_MAX/Y_MAX,
    // and the default panel (128x160 = 20480) fits in 16 bits.
    assign dx   = {1'b0, fill_x1} - {1'b0, fill_x0} + 9'd1;
    assign dy   = {1'b0, fill_y1} - {1'b0, fill_y0} + 9'd1;
    assign area = 16'(dx) * 16'(dy);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_INIT_SLPOUT;
            wait_cnt  <= '0;
            arg_idx   <= '0;
            pix_cnt   <= '0;
            x0_r      <= '0;
            x1_r      <= '0;
            y0_r      <= '0;
            y1_r      <= '0;
            color_r   <= '0;
            spi_data  <= 8'h00;
            spi_dc    <= 1'b0;
            spi_cs    <= 1'b1;
            busy      <= 1'b1;
            init_done <= 1'b0;
            fill_ack  <= 1'b0;
            fill_err  <= 1'b0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_d;
            arg_idx   <= arg_d;
            pix_cnt   <= pix_d;
            spi_data  <= data_d;
            spi_dc    <= dc_d;
            spi_cs    <= cs_d;
            busy      <= (state_d != S_IDLE);
            init_done <= init_done | (state_d == S_IDLE);
            fill_ack  <= accept;
            fill_err  <= accept && !rect_ok;
            if (accept) begin
                x0_r    <= fill_x0;
                x1_r    <= fill_x1;
                y0_r    <= fill_y0;
                y1_r    <= fill_y1;
                color_r <= fill_color;
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state;
        wait_d  = wait_cnt;
        arg_d   = arg_idx;
        pix_d   = pix_cnt;
        case (state)
            S_INIT_SLPOUT: if (byte_done) begin
                state_d = S_INIT_WAIT;
                wait_d  = '0;
            end
            S_INIT_WAIT: begin
                if (wait_cnt == WAKE_LAST) state_d = S_INIT_COLMOD;
                else                       wait_d  = wait_cnt + 32'd1;
            end
            S_INIT_COLMOD: if (byte_done) state_d = S_INIT_COLARG;
            S_INIT_COLARG: if (byte_done) state_d = S_INIT_DISPON;
            S_INIT_DISPON: if (byte_done) state_d = S_CS_GAP;
            S_CS_GAP:      state_d = S_IDLE;
            S_IDLE: begin
                // Illegal rectangles are acknowledged but never leave IDLE.
                if (fill_req && rect_ok) begin
                    state_d = S_ACCEPT;
                    pix_d   = area;
                end
            end
            S_ACCEPT: begin
                state_d = S_CASET_CMD;
                arg_d   = '0;
            end
            S_CASET_CMD: if (byte_done) begin
                state_d = S_CASET_ARG;
                arg_d   = '0;
            end
            S_CASET_ARG: if (byte_done) begin
                if (arg_idx == 3'd3) begin
                    state_d = S_RASET_CMD;
                    arg_d   = '0;
                end else begin
                    arg_d = arg_idx + 3'd1;
                end
            end
            S_RASET_CMD: if (byte_done) begin
                state_d = S_RASET_ARG;
                arg_d   = '0;
            end
            S_RASET_ARG: if (byte_done) begin
                if (arg_idx == 3'd3) begin
                    state_d = S_RAMWR;
                    arg_d   = '0;
                end else begin
                    arg_d = arg_idx + 3'd1;
                end
            end
            S_RAMWR:  if (byte_done) state_d = S_PIX_HI;
            S_PIX_HI: if (byte_done) state_d = S_PIX_LO;
            S_PIX_LO: if (byte_done) begin
                pix_d = pix_cnt - 16'd1;
                if (pix_cnt == 16'd1) state_d = S_CS_GAP;
                else                  state_d = S_PIX_HI;
            end
            default: state_d = S_INIT_SLPOUT;
        endcase
    end

    // --------------------------------------------------------------- output
    // Decoded from the next state so the registered byte lines up with the
    // state it belongs to.
    always_comb begin
        cs_d   = 1'b0;
        dc_d   = 1'b0;
        data_d = 8'h00;
        case (state_d)
            S_INIT_SLPOUT: data_d = 8'h11;
            S_INIT_COLMOD: data_d = 8'h3A;
            S_INIT_COLARG: begin
                data_d = 8'h55;
                dc_d   = 1'b1;
            end
            S_INIT_DISPON: data_d = 8'h29;
            S_CASET_CMD:   data_d = 8'h2A;
            S_CASET_ARG: begin
                dc_d = 1'b1;
                if (arg_d == 3'd1)      data_d = x0_r;
                else if (arg_d == 3'd3) data_d = x1_r;
            end
            S_RASET_CMD:   data_d = 8'h2B;
            S_RASET_ARG: begin
                dc_d = 1'b1;
                if (arg_d == 3'd1)      data_d = y0_r;
                else if (arg_d == 3'd3) data_d = y1_r;
            end
            S_RAMWR:       data_d = 8'h2C;
            S_PIX_HI: begin
                data_d = color_r[15:8];
                dc_d   = 1'b1;
            end
            S_PIX_LO: begin
                data_d = color_r[7:0];
                dc_d   = 1'b1;
            end
            // INIT_WAIT, CS_GAP, IDLE, ACCEPT: chip select released.
            default: cs_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_lcd_fill_ctrl.sv
// Testbench for lcd_fill_ctrl: serializer model answers every byte 16 cycles
// after it appears; expected {dc,data} bytes are queued as stimulus is issued
// and a monitor pops and compares each byte as the serializer completes it.

module tb_lcd_fill_ctrl;

    localparam int WAKE = 20;

    logic        clk;
    logic        reset;
    logic        fill_req;
    logic [7:0]  fill_x0, fill_x1, fill_y0, fill_y1;
    logic [15:0] fill_color;
    logic        fill_ack, fill_err, busy, init_done;
    logic [7:0]  spi_data;
    logic        spi_dc, spi_cs, spi_done;
    logic [3:0]  state_dbg;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  exp_q[$];
    int          cs_runs[$];
    int          ack_count = 0;
    int          err_count = 0;
    int          cs_rises = 0;
    int          cs_cnt;
    logic        prev_cs;
    int          ser_cnt;
    logic [8:0]  exp_b;

    lcd_fill_ctrl #(
        .WAKE_CYCLES(WAKE),
        .X_MAX(127),
        .Y_MAX(159)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fill_req(fill_req),
        .fill_x0(fill_x0),
        .fill_x1(fill_x1),
        .fill_y0(fill_y0),
        .fill_y1(fill_y1),
        .fill_color(fill_color),
        .fill_ack(fill_ack),
        .fill_err(fill_err),
        .busy(busy),
        .init_done(init_done),
        .spi_data(spi_data),
        .spi_dc(spi_dc),
        .spi_cs(spi_cs),
        .spi_done(spi_done),
        .state_dbg(state_dbg)
    );

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic dc, input logic [7:0] data);
        exp_q.push_back({dc, data});
    endtask

    task automatic push_header(input logic [7:0] x0, input logic [7:0] x1,
                               input logic [7:0] y0, input logic [7:0] y1);
        push_byte(1'b0, 8'h2A);
        push_byte(1'b1, 8'h00); push_byte(1'b1, x0);
        push_byte(1'b1, 8'h00); push_byte(1'b1, x1);
        push_byte(1'b0, 8'h2B);
        push_byte(1'b1, 8'h00); push_byte(1'b1, y0);
        push_byte(1'b1, 8'h00); push_byte(1'b1, y1);
        push_byte(1'b0, 8'h2C);
    endtask

    task automatic push_pixels(input logic [15:0] color, input int n);
        for (int i = 0; i < n; i++) begin
            push_byte(1'b1, color[15:8]);
            push_byte(1'b1, color[7:0]);
        end
    endtask

    task automatic push_init();
        push_byte(1'b0, 8'h11);
        push_byte(1'b0, 8'h3A);
        push_byte(1'b1, 8'h55);
        push_byte(1'b0, 8'h29);
    endtask

    task automatic wait_empty(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk); #2;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_init(input string name, input int max_cycles);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < max_cycles) begin
            @(negedge clk); #2;
            n++;
        end
        check(name, init_done, 1'b1);
    endtask

    // Drives a request, holds it until fill_ack, then drops it.
    task automatic issue_req(input logic [7:0] x0, input logic [7:0] x1,
                             input logic [7:0] y0, input logic [7:0] y1,
                             input logic [15:0] color,
                             output logic got_ack, output logic got_err, output int lat);
        @(negedge clk); #2;
        fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1;
        fill_color = color;
        fill_req = 1'b1;
        got_ack = 1'b0;
        got_err = 1'b0;
        lat = 0;
        while (!got_ack && lat < 20) begin
            @(negedge clk); #2;
            lat++;
            if (fill_ack) begin
                got_ack = 1'b1;
                got_err = fill_err;
            end
        end
        fill_req = 1'b0;
    endtask

    task automatic run_legal(input string name,
                             input logic [7:0] x0, input logic [7:0] x1,
                             input logic [7:0] y0, input logic [7:0] y1,
                             input logic [15:0] color, input int npix);
        logic a, e;
        int   lat, rises0;
        push_header(x0, x1, y0, y1);
        push_pixels(color, npix);
        issue_req(x0, x1, y0, y1, color, a, e, lat);
        check({name, "_ack"}, a, 1'b1);
        check({name, "_err"}, e, 1'b0);
        check({name, "_ack_latency"}, lat, 1);
        @(negedge clk); #2;
        check({name, "_first_cs"}, spi_cs, 1'b0);
        check({name, "_first_byte"}, {spi_dc, spi_data}, 9'h02A);
        rises0 = cs_rises;
        wait_empty({name, "_stream_done"}, 40 * (11 + 2 * npix));
        check({name, "_cs_low_throughout"}, cs_rises, rises0);
        @(negedge clk); #2;
        check({name, "_gap_cs"}, spi_cs, 1'b1);
        check({name, "_gap_busy"}, busy, 1'b1);
        @(negedge clk); #2;
        check({name, "_idle_busy"}, busy, 1'b0);
        check({name, "_cs_rises"}, cs_rises, rises0 + 1);
    endtask

    task automatic run_illegal(input string name,
                               input logic [7:0] x0, input logic [7:0] x1,
                               input logic [7:0] y0, input logic [7:0] y1);
        logic a, e, quiet;
        int   lat;
        issue_req(x0, x1, y0, y1, 16'hFFFF, a, e, lat);
        check({name, "_ack"}, a, 1'b1);
        check({name, "_err"}, e, 1'b1);
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (spi_cs !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
            @(negedge clk); #2;
        end
        check({name, "_no_activity"}, quiet, 1'b1);
    endtask

    // ---------------------------------------------------- serializer model
    initial begin
        spi_done = 1'b0;
        ser_cnt  = 0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (reset || spi_cs) begin
                ser_cnt = 0;
            end else begin
                ser_cnt++;
                if (ser_cnt == 16) begin
                    spi_done = 1'b1;
                    ser_cnt  = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------- scoreboard
    initial begin
        forever begin
            @(negedge clk); #1;
            if (fill_ack === 1'b1) ack_count++;
            if (fill_err === 1'b1) err_count++;
            if (spi_done && spi_cs === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got dc=%0b data=%02h with nothing expected",
                             spi_dc, spi_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("spi_byte", {spi_dc, spi_data}, exp_b);
                end
            end
        end
    end

    // Chip-select high run lengths and rising edges.
    initial begin
        cs_cnt  = 0;
        prev_cs = 1'b1;
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                cs_cnt = 0;
            end else if (spi_cs) begin
                cs_cnt++;
                if (!prev_cs) cs_rises++;
            end else begin
                if (cs_cnt > 0) cs_runs.push_back(cs_cnt);
                cs_cnt = 0;
            end
            prev_cs = spi_cs;
        end
    end

    // Last-resort time limit.
    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic a, e;
        int   base, n, gap;

        reset      = 1'b1;
        fill_req   = 1'b0;
        fill_x0    = '0;
        fill_x1    = '0;
        fill_y0    = '0;
        fill_y1    = '0;
        fill_color = '0;

        repeat (3) @(negedge clk);
        #2;
        check("rst_cs", spi_cs, 1'b1);
        check("rst_dc", spi_dc, 1'b0);
        check("rst_data", spi_data, 8'h00);
        check("rst_busy", busy, 1'b1);
        check("rst_init_done", init_done, 1'b0);
        check("rst_ack", fill_ack, 1'b0);
        check("rst_err", fill_err, 1'b0);
        check("rst_state", state_dbg, 4'd0);

        // Power-up
        push_init();
        cs_runs.delete();
        reset = 1'b0;
        wait_init("init_done", 2000);
        wait_empty("init_stream", 10);
        check("init_busy", busy, 1'b0);
        check("wake_cs_high", (cs_runs.size() > 0) ? cs_runs[0] : 0, WAKE);

        // Single pixel and a 2x3 rectangle
        run_legal("single", 8'd5, 8'd5, 8'd7, 8'd7, 16'hF800, 1);
        run_legal("rect", 8'd0, 8'd1, 8'd0, 8'd2, 16'h07E0, 6);

        // Illegal rectangles
        base = err_count;
        run_illegal("illegal_x", 8'd10, 8'd9, 8'd0, 8'd0);
        run_illegal("illegal_y", 8'd0, 8'd0, 8'd0, 8'd160);
        check("illegal_err_count", err_count - base, 2);

        // Request held high across two fills
        push_header(8'd2, 8'd2, 8'd3, 8'd3);
        push_pixels(16'h1234, 1);
        push_header(8'd2, 8'd2, 8'd3, 8'd3);
        push_pixels(16'h1234, 1);
        base = ack_count;
        @(negedge clk); #2;
        fill_x0 = 8'd2; fill_x1 = 8'd2; fill_y0 = 8'd3; fill_y1 = 8'd3;
        fill_color = 16'h1234;
        fill_req = 1'b1;
        n = 0;
        while (ack_count < base + 2 && n < 2000) begin
            @(negedge clk); #2;
            n++;
        end
        fill_req = 1'b0;
        check("held_two_acks", ack_count - base, 2);
        wait_empty("held_stream", 1000);
        gap = (cs_runs.size() > 0) ? cs_runs[cs_runs.size() - 1] : 0;
        check("held_gap_ge2", (gap >= 2), 1'b1);
        repeat (20) @(negedge clk);
        #2;
        check("held_no_extra_ack", ack_count - base, 2);

        // Reset during the third pixel byte
        push_header(8'd0, 8'd1, 8'd0, 8'd2);
        push_pixels(16'h07E0, 1);
        issue_req(8'd0, 8'd1, 8'd0, 8'd2, 16'h07E0, a, e, n);
        check("mid_ack", a, 1'b1);
        wait_empty("mid_two_pixel_bytes", 1000);
        repeat (5) @(negedge clk);
        #2;
        check("mid_third_byte_on_wire", {spi_cs, spi_dc, spi_data}, {1'b0, 1'b1, 8'h07});
        reset = 1'b1;
        @(negedge clk); #2;
        check("mid_rst_cs", spi_cs, 1'b1);
        check("mid_rst_init_done", init_done, 1'b0);
        check("mid_rst_busy", busy, 1'b1);
        check("mid_rst_data", spi_data, 8'h00);
        repeat (2) @(negedge clk);
        #2;
        push_init();
        cs_runs.delete();
        reset = 1'b0;
        wait_init("reinit_done", 2000);
        wait_empty("reinit_stream", 10);
        check("rewake_cs_high", (cs_runs.size() > 0) ? cs_runs[0] : 0, WAKE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
